// File: rtl/tone_sequencer.sv
// Tone sequencer: descriptor FIFO, phase-continuous chirping phase accumulator
// and per-sample pacing around an external request/done CORDIC.
module tone_sequencer #(
    parameter int unsigned PHASE_W     = 30,
    parameter int unsigned AMP_W       = 30,
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned CNT_W       = 8,
    parameter int unsigned LEN_W       = 16,
    parameter int unsigned CORDIC_LEAD = 31
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [CNT_W-1:0]   cfg_period,
    input  logic               start,
    input  logic               stop,
    input  logic               tone_valid,
    output logic               tone_ready,
    input  logic [PHASE_W-1:0] tone_fcw,
    input  logic [LEN_W-1:0]   tone_len,
    input  logic [PHASE_W-1:0] tone_chirp,
    output logic               cor_req,
    output logic [PHASE_W-1:0] cor_theta,
    input  logic               cor_done,
    input  logic [AMP_W-1:0]   cor_x,
    input  logic [AMP_W-1:0]   cor_y,
    output logic [AMP_W-1:0]   smp_cos,
    output logic [AMP_W-1:0]   smp_sin,
    output logic               smp_strb,
    output logic               active,
    output logic               late,
    output logic               done
);

    localparam int unsigned      PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned      OCC_W  = PTR_W + 1;
    localparam logic [CNT_W-1:0] LEAD_C = CNT_W'(CORDIC_LEAD);
    localparam logic [OCC_W-1:0] FULL_C = OCC_W'(FIFO_DEPTH);

    typedef struct packed {
        logic [PHASE_W-1:0] fcw;
        logic [LEN_W-1:0]   len;
        logic [PHASE_W-1:0] chirp;
    } tone_desc_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_PRIME,
        S_RUN,
        S_STALL
    } state_t;

    state_t             state_q, state_d;
    tone_desc_t         fifo_q [FIFO_DEPTH];
    tone_desc_t         fifo_d [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0]   occ_q, occ_d;
    logic               tone_ready_q, tone_ready_d;
    logic [PHASE_W-1:0] fcw_q, fcw_d;
    logic [PHASE_W-1:0] chirp_q, chirp_d;
    logic [PHASE_W-1:0] theta_q, theta_d;
    logic [LEN_W-1:0]   rem_q, rem_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               req_issued_q, req_issued_d;
    logic               last_q, last_d;
    logic               stop_seen_q, stop_seen_d;
    logic               pend_q, pend_d;
    logic [AMP_W-1:0]   pend_x_q, pend_x_d;
    logic [AMP_W-1:0]   pend_y_q, pend_y_d;
    logic [AMP_W-1:0]   smp_cos_q, smp_cos_d;
    logic [AMP_W-1:0]   smp_sin_q, smp_sin_d;
    logic               cor_req_q, cor_req_d;
    logic               smp_strb_q, smp_strb_d;
    logic               late_q, late_d;
    logic               done_q, done_d;
    logic               active_q;

    logic               push;
    logic               pop;
    logic               fifo_empty;
    logic               lead;
    logic               lead_last;
    tone_desc_t         head;
    tone_desc_t         desc_in;

    function automatic logic [LEN_W-1:0] first_rem(input logic [LEN_W-1:0] len);
        return (len == '0) ? '0 : len - LEN_W'(1);
    endfunction

    assign desc_in    = '{fcw: tone_fcw, len: tone_len, chirp: tone_chirp};
    assign head       = fifo_q[rd_ptr_q];
    assign fifo_empty = (occ_q == '0);
    assign push       = tone_valid && tone_ready_q;
    assign lead       = (state_q == S_RUN) && !req_issued_q && (cnt_q <= LEAD_C);
    // A tone ending with nothing queued must be known at the boundary even when
    // the lead point lands on that same cycle (single-cycle sample periods).
    assign lead_last  = lead && (rem_q == '0) && fifo_empty;

    // Next-state, datapath and FIFO bookkeeping.
    always_comb begin
        state_d      = state_q;
        fcw_d        = fcw_q;
        chirp_d      = chirp_q;
        theta_d      = theta_q;
        rem_d        = rem_q;
        cnt_d        = cnt_q;
        req_issued_d = req_issued_q;
        last_d       = last_q;
        stop_seen_d  = stop_seen_q;
        pend_d       = pend_q;
        pend_x_d     = pend_x_q;
        pend_y_d     = pend_y_q;
        smp_cos_d    = smp_cos_q;
        smp_sin_d    = smp_sin_q;
        late_d       = late_q;
        cor_req_d    = 1'b0;
        smp_strb_d   = 1'b0;
        done_d       = 1'b0;
        pop          = 1'b0;
        fifo_d       = fifo_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        occ_d        = occ_q;

        case (state_q)
            S_IDLE: begin
                if (start && !fifo_empty) begin
                    pop          = 1'b1;
                    fcw_d        = head.fcw;
                    chirp_d      = head.chirp;
                    rem_d        = first_rem(head.len);
                    theta_d      = '0;
                    cor_req_d    = 1'b1;
                    late_d       = 1'b0;
                    last_d       = 1'b0;
                    stop_seen_d  = 1'b0;
                    pend_d       = 1'b0;
                    req_issued_d = 1'b0;
                    state_d      = S_PRIME;
                end
            end

            S_PRIME: begin
                if (stop) begin
                    stop_seen_d = 1'b1;
                end
                if (cor_done) begin
                    smp_cos_d    = cor_x;
                    smp_sin_d    = cor_y;
                    smp_strb_d   = 1'b1;
                    cnt_d        = cfg_period;
                    req_issued_d = 1'b0;
                    pend_d       = 1'b0;
                    state_d      = S_RUN;
                end
            end

            S_RUN: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (stop) begin
                    stop_seen_d = 1'b1;
                end
                if (cor_done) begin
                    pend_d   = 1'b1;
                    pend_x_d = cor_x;
                    pend_y_d = cor_y;
                end
                if (lead) begin
                    req_issued_d = 1'b1;
                    if (rem_q != '0) begin
                        theta_d   = theta_q + fcw_q;
                        fcw_d     = fcw_q + chirp_q;
                        rem_d     = rem_q - LEN_W'(1);
                        cor_req_d = 1'b1;
                    end else if (!fifo_empty) begin
                        pop       = 1'b1;
                        theta_d   = theta_q + fcw_q;
                        fcw_d     = head.fcw;
                        chirp_d   = head.chirp;
                        rem_d     = first_rem(head.len);
                        cor_req_d = 1'b1;
                    end else begin
                        last_d = 1'b1;
                    end
                end
                if (cnt_q == '0) begin
                    if (stop_seen_q || stop || last_q || lead_last) begin
                        done_d      = 1'b1;
                        cnt_d       = '0;
                        pend_d      = 1'b0;
                        stop_seen_d = 1'b0;
                        state_d     = S_IDLE;
                    end else if (pend_q || cor_done) begin
                        // A result landing exactly on the boundary is still on time.
                        smp_cos_d    = pend_q ? pend_x_q : cor_x;
                        smp_sin_d    = pend_q ? pend_y_q : cor_y;
                        smp_strb_d   = 1'b1;
                        cnt_d        = cfg_period;
                        pend_d       = 1'b0;
                        req_issued_d = 1'b0;
                        stop_seen_d  = 1'b0;
                    end else begin
                        late_d  = 1'b1;
                        cnt_d   = '0;
                        state_d = S_STALL;
                    end
                end
            end

            S_STALL: begin
                if (stop) begin
                    stop_seen_d = 1'b1;
                end
                if (cor_done) begin
                    smp_cos_d    = cor_x;
                    smp_sin_d    = cor_y;
                    smp_strb_d   = 1'b1;
                    cnt_d        = cfg_period;
                    req_issued_d = 1'b0;
                    state_d      = S_RUN;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (push) begin
            fifo_d[wr_ptr_q] = desc_in;
            wr_ptr_d         = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        occ_d        = occ_q + OCC_W'(push) - OCC_W'(pop);
        tone_ready_d = (occ_d != FULL_C);
    end

    // Descriptor storage needs no reset; occupancy guards every read.
    always_ff @(posedge clk) begin
        fifo_q <= fifo_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            occ_q        <= '0;
            tone_ready_q <= 1'b0;
            fcw_q        <= '0;
            chirp_q      <= '0;
            theta_q      <= '0;
            rem_q        <= '0;
            cnt_q        <= '0;
            req_issued_q <= 1'b0;
            last_q       <= 1'b0;
            stop_seen_q  <= 1'b0;
            pend_q       <= 1'b0;
            pend_x_q     <= '0;
            pend_y_q     <= '0;
            smp_cos_q    <= '0;
            smp_sin_q    <= '0;
            cor_req_q    <= 1'b0;
            smp_strb_q   <= 1'b0;
            late_q       <= 1'b0;
            done_q       <= 1'b0;
            active_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            occ_q        <= occ_d;
            tone_ready_q <= tone_ready_d;
            fcw_q        <= fcw_d;
            chirp_q      <= chirp_d;
            theta_q      <= theta_d;
            rem_q        <= rem_d;
            cnt_q        <= cnt_d;
            req_issued_q <= req_issued_d;
            last_q       <= last_d;
            stop_seen_q  <= stop_seen_d;
            pend_q       <= pend_d;
            pend_x_q     <= pend_x_d;
            pend_y_q     <= pend_y_d;
            smp_cos_q    <= smp_cos_d;
            smp_sin_q    <= smp_sin_d;
            cor_req_q    <= cor_req_d;
            smp_strb_q   <= smp_strb_d;
            late_q       <= late_d;
            done_q       <= done_d;
            active_q     <= (state_d != S_IDLE);
        end
    end

    assign tone_ready = tone_ready_q;
    assign cor_req    = cor_req_q;
    assign cor_theta  = theta_q;
    assign smp_cos    = smp_cos_q;
    assign smp_sin    = smp_sin_q;
    assign smp_strb   = smp_strb_q;
    assign active     = active_q;
    assign late       = late_q;
    assign done       = done_q;

endmodule

// File: tb/tb_tone_sequencer.sv
// Directed bench for tone_sequencer with a latency-programmable CORDIC stand-in
// whose results are cos = theta + 1, sin = theta + 2.
module tb_tone_sequencer;

    localparam int unsigned PW      = 30;
    localparam int unsigned AW      = 30;
    localparam int unsigned DEPTH   = 4;
    localparam int unsigned CW      = 8;
    localparam int unsigned LW      = 16;
    localparam int unsigned LEAD    = 3;
    localparam int          SPACING = 8;

    logic          clk;
    logic          reset;
    logic [CW-1:0] cfg_period;
    logic          start;
    logic          stop;
    logic          tone_valid;
    logic          tone_ready;
    logic [PW-1:0] tone_fcw;
    logic [LW-1:0] tone_len;
    logic [PW-1:0] tone_chirp;
    logic          cor_req;
    logic [PW-1:0] cor_theta;
    logic          cor_done;
    logic [AW-1:0] cor_x;
    logic [AW-1:0] cor_y;
    logic [AW-1:0] smp_cos;
    logic [AW-1:0] smp_sin;
    logic          smp_strb;
    logic          active;
    logic          late;
    logic          done;

    tone_sequencer #(
        .PHASE_W    (PW),
        .AMP_W      (AW),
        .FIFO_DEPTH (DEPTH),
        .CNT_W      (CW),
        .LEN_W      (LW),
        .CORDIC_LEAD(LEAD)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cfg_period(cfg_period),
        .start     (start),
        .stop      (stop),
        .tone_valid(tone_valid),
        .tone_ready(tone_ready),
        .tone_fcw  (tone_fcw),
        .tone_len  (tone_len),
        .tone_chirp(tone_chirp),
        .cor_req   (cor_req),
        .cor_theta (cor_theta),
        .cor_done  (cor_done),
        .cor_x     (cor_x),
        .cor_y     (cor_y),
        .smp_cos   (smp_cos),
        .smp_sin   (smp_sin),
        .smp_strb  (smp_strb),
        .active    (active),
        .late      (late),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // CORDIC stand-in: request seen in cycle c gives cor_done in cycle c + cor_lat.
    int unsigned   cor_lat;
    int unsigned   lat_cnt   = 0;
    logic [PW-1:0] lat_theta = '0;
    always @(posedge clk) begin
        if (cor_req === 1'b1) begin
            lat_cnt   <= cor_lat;
            lat_theta <= cor_theta;
        end else if (lat_cnt != 0) begin
            lat_cnt <= lat_cnt - 1;
        end
    end
    assign cor_done = (lat_cnt == 1);
    assign cor_x    = AW'(lat_theta) + AW'(1);
    assign cor_y    = AW'(lat_theta) + AW'(2);

    int            n_checks;
    int            n_pass;
    int            cyc;
    logic [PW-1:0] req_q[$];
    int            strb_c[$];
    logic [AW-1:0] cos_q[$];
    logic [AW-1:0] sin_q[$];
    int            done_c[$];
    int            cdone_c[$];

    typedef struct {
        logic [PW-1:0]         fcw_a;
        logic [LW-1:0]         len_a;
        logic [PW-1:0]         chirp_a;
        logic                  use_b;
        logic [PW-1:0]         fcw_b;
        logic [LW-1:0]         len_b;
        int                    n;
        logic [3:0][PW-1:0]    th;
    } scen_t;

    typedef struct {
        logic          valid;
        logic          start;
        logic [PW-1:0] fcw;
        logic          exp_ready;
        logic          exp_active;
    } frow_t;

    scen_t sc[6];
    frow_t rows[11];

    function automatic scen_t mk(input logic [PW-1:0] fa, input logic [LW-1:0] la,
                                 input logic [PW-1:0] ca, input logic ub,
                                 input logic [PW-1:0] fb, input logic [LW-1:0] lb,
                                 input int n, input logic [PW-1:0] t0, input logic [PW-1:0] t1,
                                 input logic [PW-1:0] t2, input logic [PW-1:0] t3);
        scen_t s;
        s.fcw_a = fa; s.len_a = la; s.chirp_a = ca;
        s.use_b = ub; s.fcw_b = fb; s.len_b = lb; s.n = n;
        s.th[0] = t0; s.th[1] = t1; s.th[2] = t2; s.th[3] = t3;
        return s;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
        if (cor_req === 1'b1) req_q.push_back(cor_theta);
        if (smp_strb === 1'b1) begin
            strb_c.push_back(cyc);
            cos_q.push_back(smp_cos);
            sin_q.push_back(smp_sin);
        end
        if (done === 1'b1) done_c.push_back(cyc);
        if (cor_done === 1'b1) cdone_c.push_back(cyc);
    endtask

    task automatic clear();
        req_q.delete(); strb_c.delete(); cos_q.delete();
        sin_q.delete(); done_c.delete(); cdone_c.delete();
    endtask

    task automatic push(input logic [PW-1:0] f, input logic [LW-1:0] l, input logic [PW-1:0] c);
        int b;
        b = 0;
        tone_fcw = f; tone_len = l; tone_chirp = c; tone_valid = 1'b1;
        while (tone_ready !== 1'b1 && b < 20) begin
            step();
            b++;
        end
        check("push_ready", 64'(tone_ready), 64'(1));
        step();
        tone_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int b;
        b = 0;
        while (done_c.size() == 0 && b < budget) begin
            step();
            b++;
        end
        check("done_seen", 64'(done_c.size()), 64'(1));
    endtask

    task automatic wait_strb(input int budget);
        int b;
        b = 0;
        while (strb_c.size() == 0 && b < budget) begin
            step();
            b++;
        end
        check("first_strb_seen", 64'(strb_c.size()), 64'(1));
    endtask

    task automatic run_scen(input int i, input scen_t s);
        push(s.fcw_a, s.len_a, s.chirp_a);
        if (s.use_b) push(s.fcw_b, s.len_b, '0);
        clear();
        pulse_start();
        wait_done(300);
        check($sformatf("s%0d_active_fall", i), 64'(active), 64'(0));
        check($sformatf("s%0d_late", i), 64'(late), 64'(0));
        check($sformatf("s%0d_nreq", i), 64'(req_q.size()), 64'(s.n));
        check($sformatf("s%0d_nstrb", i), 64'(strb_c.size()), 64'(s.n));
        for (int k = 0; k < s.n && k < req_q.size(); k++)
            check($sformatf("s%0d_theta%0d", i, k), 64'(req_q[k]), 64'(s.th[k]));
        for (int k = 0; k < s.n && k < cos_q.size(); k++)
            check($sformatf("s%0d_cos%0d", i, k), 64'(cos_q[k]), 64'(AW'(s.th[k]) + AW'(1)));
        for (int k = 1; k < strb_c.size(); k++)
            check($sformatf("s%0d_spacing%0d", i, k), 64'(strb_c[k] - strb_c[k-1]), 64'(SPACING));
        if (done_c.size() > 0 && strb_c.size() > 0)
            check($sformatf("s%0d_done_time", i), 64'(done_c[0] - strb_c[strb_c.size()-1]),
                  64'(SPACING));
        repeat (4) step();
    endtask

    initial begin
        n_checks = 0; n_pass = 0; cyc = 0;
        reset = 1'b1; start = 1'b0; stop = 1'b0; tone_valid = 1'b0;
        tone_fcw = '0; tone_len = '0; tone_chirp = '0;
        cfg_period = CW'(7); cor_lat = 2;

        sc[0] = mk(30'h100, 16'd3, 30'h0, 1'b0, 30'h0, 16'd0, 3,
                   30'h0, 30'h100, 30'h200, 30'h0);
        sc[1] = mk(30'h10, 16'd2, 30'h0, 1'b1, 30'h40, 16'd2, 4,
                   30'h0, 30'h10, 30'h20, 30'h60);
        sc[2] = mk(30'h10, 16'd4, 30'h8, 1'b0, 30'h0, 16'd0, 4,
                   30'h0, 30'h10, 30'h28, 30'h48);
        sc[3] = mk(30'h55, 16'd0, 30'h0, 1'b0, 30'h0, 16'd0, 1,
                   30'h0, 30'h0, 30'h0, 30'h0);
        sc[4] = mk(30'h3FFF_FFF0, 16'd3, 30'h0, 1'b0, 30'h0, 16'd0, 3,
                   30'h0, 30'h3FFF_FFF0, 30'h3FFF_FFE0, 30'h0);
        sc[5] = mk(30'h40, 16'd3, 30'h3FFF_FFF0, 1'b0, 30'h0, 16'd0, 3,
                   30'h0, 30'h40, 30'h70, 30'h0);

        // {valid, start, fcw, ready seen before this cycle, active seen before this cycle}
        rows[0]  = '{1'b0, 1'b1, 30'd0, 1'b1, 1'b0};
        rows[1]  = '{1'b1, 1'b0, 30'd1, 1'b1, 1'b0};
        rows[2]  = '{1'b1, 1'b0, 30'd2, 1'b1, 1'b0};
        rows[3]  = '{1'b1, 1'b0, 30'd3, 1'b1, 1'b0};
        rows[4]  = '{1'b1, 1'b0, 30'd4, 1'b1, 1'b0};
        rows[5]  = '{1'b1, 1'b0, 30'd5, 1'b0, 1'b0};
        rows[6]  = '{1'b1, 1'b0, 30'd5, 1'b0, 1'b0};
        rows[7]  = '{1'b1, 1'b1, 30'd5, 1'b0, 1'b0};
        rows[8]  = '{1'b1, 1'b0, 30'd5, 1'b1, 1'b1};
        rows[9]  = '{1'b0, 1'b0, 30'd0, 1'b0, 1'b1};
        rows[10] = '{1'b0, 1'b0, 30'd0, 1'b0, 1'b1};

        // Reset state
        repeat (3) step();
        check("rst_tone_ready", 64'(tone_ready), 64'(0));
        check("rst_cor_req",    64'(cor_req),    64'(0));
        check("rst_cor_theta",  64'(cor_theta),  64'(0));
        check("rst_smp_cos",    64'(smp_cos),    64'(0));
        check("rst_smp_sin",    64'(smp_sin),    64'(0));
        check("rst_smp_strb",   64'(smp_strb),   64'(0));
        check("rst_active",     64'(active),     64'(0));
        check("rst_late",       64'(late),       64'(0));
        check("rst_done",       64'(done),       64'(0));
        reset = 1'b0;
        step();
        check("ready_after_rst", 64'(tone_ready), 64'(1));

        for (int i = 0; i < 6; i++) run_scen(i, sc[i]);

        // Late CORDIC: second sample stalls, strobe follows cor_done, period restarts there
        cor_lat = 6;
        push(30'h20, 16'd2, 30'h0);
        clear();
        pulse_start();
        wait_done(300);
        check("late_flag", 64'(late), 64'(1));
        check("late_nstrb", 64'(strb_c.size()), 64'(2));
        check("late_ncdone", 64'(cdone_c.size()), 64'(2));
        if (strb_c.size() == 2 && cdone_c.size() == 2) begin
            check("late_prime_strb", 64'(strb_c[0] - cdone_c[0]), 64'(1));
            check("late_stall_strb", 64'(strb_c[1] - cdone_c[1]), 64'(1));
            check("late_gap", 64'(strb_c[1] - strb_c[0]), 64'(12));
            check("late_sin1", 64'(sin_q[1]), 64'(AW'('h22)));
        end
        if (done_c.size() > 0 && strb_c.size() == 2)
            check("late_done_time", 64'(done_c[0] - strb_c[1]), 64'(SPACING));
        cor_lat = 2;
        repeat (4) step();

        // Stop mid-sample on a long tone
        push(30'h40, 16'd10, 30'h0);
        clear();
        pulse_start();
        wait_strb(50);
        check("late_cleared_by_start", 64'(late), 64'(0));
        repeat (3) step();
        stop = 1'b1;
        step();
        stop = 1'b0;
        wait_done(50);
        check("stop_nstrb", 64'(strb_c.size()), 64'(1));
        if (done_c.size() > 0 && strb_c.size() > 0)
            check("stop_done_time", 64'(done_c[0] - strb_c[0]), 64'(SPACING));
        repeat (4) step();

        // Stop in the final sample of a tone: one done only
        push(30'h40, 16'd1, 30'h0);
        clear();
        pulse_start();
        wait_strb(50);
        repeat (2) step();
        stop = 1'b1;
        step();
        stop = 1'b0;
        wait_done(50);
        repeat (10) step();
        check("stop_end_ndone", 64'(done_c.size()), 64'(1));
        if (done_c.size() > 0 && strb_c.size() > 0)
            check("stop_end_done_time", 64'(done_c[0] - strb_c[0]), 64'(SPACING));

        // FIFO full/empty table
        clear();
        tone_len = 16'd1; tone_chirp = '0;
        for (int i = 0; i < 11; i++) begin
            check($sformatf("fifo_ready%0d", i),  64'(tone_ready), 64'(rows[i].exp_ready));
            check($sformatf("fifo_active%0d", i), 64'(active),     64'(rows[i].exp_active));
            tone_valid = rows[i].valid;
            start      = rows[i].start;
            tone_fcw   = rows[i].fcw;
            step();
        end
        tone_valid = 1'b0;
        start      = 1'b0;
        wait_done(400);
        check("fifo_nreq", 64'(req_q.size()), 64'(5));
        if (req_q.size() == 5) begin
            check("fifo_theta1", 64'(req_q[1]), 64'(1));
            check("fifo_theta2", 64'(req_q[2]), 64'(3));
            check("fifo_theta3", 64'(req_q[3]), 64'(6));
            check("fifo_theta4", 64'(req_q[4]), 64'(10));
        end
        repeat (4) step();

        // Reset during PRIME with a cor_done still in flight
        cor_lat = 6;
        push(30'h77, 16'd4, 30'h0);
        clear();
        pulse_start();
        step();
        reset = 1'b1;
        repeat (2) step();
        check("midrst_active",    64'(active),    64'(0));
        check("midrst_cor_req",   64'(cor_req),   64'(0));
        check("midrst_smp_cos",   64'(smp_cos),   64'(0));
        check("midrst_smp_sin",   64'(smp_sin),   64'(0));
        check("midrst_late",      64'(late),      64'(0));
        check("midrst_done",      64'(done),      64'(0));
        check("midrst_ready",     64'(tone_ready), 64'(0));
        reset = 1'b0;
        repeat (12) step();
        check("midrst_cdone_arrived", 64'(cdone_c.size()), 64'(1));
        check("midrst_no_strb",   64'(strb_c.size()), 64'(0));
        check("midrst_idle",      64'(active),    64'(0));
        check("midrst_hold_cos",  64'(smp_cos),   64'(0));
        check("midrst_ready_back", 64'(tone_ready), 64'(1));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
